// File: rtl/seq_line_pkg.sv
// rtl/seq_line_pkg.sv - shared line constants and state encoding for the 110-marker serial link
package seq_line_pkg;

    // Frame marker, sent MSB first; the detector watches for this pattern
    localparam int SYNC_W = 3;
    localparam logic [SYNC_W-1:0] SYNC = 3'b110;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_SYNC = 3'd1,
        ST_DATA = 3'd2,
        ST_PAR  = 3'd3,
        ST_GAP  = 3'd4
    } line_state_e;

    // Counter width for values 0..n-1, never narrower than one bit
    function automatic int clog2_min1(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/bit_tick_gen.sv
// rtl/bit_tick_gen.sv - bit-period divider producing a pulse on the last clk of each serial bit
module bit_tick_gen
    import seq_line_pkg::*;
#(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clr,
    output logic o_bit_end
);

    localparam int CW = clog2_min1(CLKS_PER_BIT);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] r_cnt;

    // Count clocks within a bit; held at zero while cleared, wraps after the last clk
    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_cnt <= '0;
        end else if (r_cnt == LAST) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_bit_end = (r_cnt == LAST);

endmodule

// File: rtl/seq_frame_tx.sv
// rtl/seq_frame_tx.sv - serial frame transmitter: sync marker, MSB-first payload, optional parity, idle gap
module seq_frame_tx
    import seq_line_pkg::*;
#(
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 4,
    parameter int PARITY_EN    = 1,
    parameter int GAP_BITS     = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic              x_out,
    output logic              busy,
    output logic              frame_done
);

    // Bit counter must span the longest field of the frame
    localparam int MAX_SD = (SYNC_W > DATA_W) ? SYNC_W : DATA_W;
    localparam int MAX_B  = (MAX_SD > GAP_BITS) ? MAX_SD : GAP_BITS;
    localparam int BC_W   = clog2_min1(MAX_B);

    localparam logic [BC_W-1:0] SYNC_LAST = BC_W'(SYNC_W - 1);
    localparam logic [BC_W-1:0] DATA_LAST = BC_W'(DATA_W - 1);
    localparam logic [BC_W-1:0] GAP_LAST  = BC_W'(GAP_BITS - 1);

    line_state_e       r_state;
    logic [BC_W-1:0]   r_bit_cnt;
    logic [DATA_W-1:0] r_shreg;
    logic [SYNC_W-1:0] r_sync;
    logic              r_par;
    logic              r_x;
    logic              r_ready;
    logic              r_busy;

    logic w_bit_end;
    logic w_tick_clr;

    // The divider sits at zero in IDLE so the first bit after a handshake gets full length
    assign w_tick_clr = (r_state == ST_IDLE);

    bit_tick_gen #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_bit_tick_gen (
        .clk       (clk),
        .rst       (rst),
        .i_clr     (w_tick_clr),
        .o_bit_end (w_bit_end)
    );

    // Frame sequencer: each branch loads the next line bit so x_out changes on bit boundaries
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_bit_cnt <= '0;
            r_shreg   <= '0;
            r_sync    <= '0;
            r_par     <= 1'b0;
            r_x       <= 1'b0;
            r_ready   <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_x       <= 1'b0;
                    r_busy    <= 1'b0;
                    r_ready   <= 1'b1;
                    r_bit_cnt <= '0;
                    if (tx_valid && r_ready) begin
                        r_shreg <= tx_data;
                        r_par   <= ^tx_data;
                        r_sync  <= SYNC << 1;
                        r_x     <= SYNC[SYNC_W-1];
                        r_state <= ST_SYNC;
                        r_busy  <= 1'b1;
                        r_ready <= 1'b0;
                    end
                end
                ST_SYNC: begin
                    if (w_bit_end) begin
                        if (r_bit_cnt == SYNC_LAST) begin
                            r_bit_cnt <= '0;
                            r_x       <= r_shreg[DATA_W-1];
                            r_shreg   <= r_shreg << 1;
                            r_state   <= ST_DATA;
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 1'b1;
                            r_x       <= r_sync[SYNC_W-1];
                            r_sync    <= r_sync << 1;
                        end
                    end
                end
                ST_DATA: begin
                    if (w_bit_end) begin
                        if (r_bit_cnt == DATA_LAST) begin
                            r_bit_cnt <= '0;
                            if (PARITY_EN != 0) begin
                                r_x     <= r_par;
                                r_state <= ST_PAR;
                            end else begin
                                r_x     <= 1'b0;
                                r_state <= ST_GAP;
                            end
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 1'b1;
                            r_x       <= r_shreg[DATA_W-1];
                            r_shreg   <= r_shreg << 1;
                        end
                    end
                end
                ST_PAR: begin
                    if (w_bit_end) begin
                        r_bit_cnt <= '0;
                        r_x       <= 1'b0;
                        r_state   <= ST_GAP;
                    end
                end
                ST_GAP: begin
                    if (w_bit_end) begin
                        if (r_bit_cnt == GAP_LAST) begin
                            r_bit_cnt <= '0;
                            r_state   <= ST_IDLE;
                            r_busy    <= 1'b0;
                            r_ready   <= 1'b1;
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    r_state   <= ST_IDLE;
                    r_bit_cnt <= '0;
                    r_x       <= 1'b0;
                    r_busy    <= 1'b0;
                    r_ready   <= 1'b0;
                end
            endcase
        end
    end

    // Decoded from registers only: high on the final clk of the final gap bit
    assign frame_done = (r_state == ST_GAP) && (r_bit_cnt == GAP_LAST) && w_bit_end;

    assign tx_ready = r_ready;
    assign x_out    = r_x;
    assign busy     = r_busy;

endmodule

// File: tb/tb_seq_frame_tx.sv
// tb/tb_seq_frame_tx.sv - directed self-checking bench for seq_frame_tx
module tb_seq_frame_tx;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [2:0] rst_v;
    logic [2:0] valid_v;
    logic [7:0] data_v [3];
    wire  [2:0] ready_v;
    wire  [2:0] x_v;
    wire  [2:0] busy_v;
    wire  [2:0] fd_v;

    int n_cmp = 0;
    int n_bad = 0;

    seq_frame_tx #(.DATA_W(8), .CLKS_PER_BIT(1), .PARITY_EN(1), .GAP_BITS(2)) u_a (
        .clk(clk), .rst(rst_v[0]), .tx_data(data_v[0]), .tx_valid(valid_v[0]),
        .tx_ready(ready_v[0]), .x_out(x_v[0]), .busy(busy_v[0]), .frame_done(fd_v[0]));

    seq_frame_tx #(.DATA_W(8), .CLKS_PER_BIT(4), .PARITY_EN(1), .GAP_BITS(2)) u_b (
        .clk(clk), .rst(rst_v[1]), .tx_data(data_v[1]), .tx_valid(valid_v[1]),
        .tx_ready(ready_v[1]), .x_out(x_v[1]), .busy(busy_v[1]), .frame_done(fd_v[1]));

    seq_frame_tx #(.DATA_W(8), .CLKS_PER_BIT(2), .PARITY_EN(0), .GAP_BITS(1)) u_c (
        .clk(clk), .rst(rst_v[2]), .tx_data(data_v[2]), .tx_valid(valid_v[2]),
        .tx_ready(ready_v[2]), .x_out(x_v[2]), .busy(busy_v[2]), .frame_done(fd_v[2]));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic handshake(input int d, input logic [7:0] w, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (ready_v[d] === 1'b1) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        if (ok) begin
            valid_v[d] = 1'b1;
            data_v[d]  = w;
            tick();
            valid_v[d] = 1'b0;
        end
    endtask

    task automatic capture(input int d, input int n,
                           output logic [63:0] xs, output logic [63:0] fs, output logic [63:0] bs);
        xs = '0;
        fs = '0;
        bs = '0;
        for (int i = 0; i < n; i++) begin
            xs = {xs[62:0], x_v[d]};
            fs = {fs[62:0], fd_v[d]};
            bs = {bs[62:0], busy_v[d]};
            tick();
        end
    endtask

    task automatic test_reset();
        rst_v   = 3'b111;
        valid_v = 3'b000;
        for (int d = 0; d < 3; d++) data_v[d] = 8'h00;
        tick(); tick(); tick();
        for (int d = 0; d < 3; d++) begin
            n_cmp++;
            if ({x_v[d], busy_v[d], fd_v[d], ready_v[d]} !== 4'b0000) begin
                n_bad++;
                $display("FAIL reset_outputs dut%0d: x/busy/done/ready=%b required 0000", d,
                         {x_v[d], busy_v[d], fd_v[d], ready_v[d]});
            end
        end
        rst_v = 3'b000;
        tick();
        n_cmp++;
        if (ready_v !== 3'b111) begin
            n_bad++;
            $display("FAIL ready_after_reset: got %b required 111", ready_v);
        end
    endtask

    task automatic test_basic_a5();
        bit ok;
        logic [63:0] xs, fs, bs;
        handshake(0, 8'hA5, ok);
        n_cmp++;
        if (!ok) begin n_bad++; $display("FAIL basic_handshake: ready never seen"); end
        capture(0, 14, xs, fs, bs);
        n_cmp++;
        if (xs[13:0] !== 14'b110_10100101_0_00) begin
            n_bad++;
            $display("FAIL basic_xout: got %b required %b", xs[13:0], 14'b110_10100101_0_00);
        end
        n_cmp++;
        if (fs[13:0] !== 14'b00000000000001) begin
            n_bad++;
            $display("FAIL basic_frame_done: got %b required %b", fs[13:0], 14'b1);
        end
        n_cmp++;
        if ({ready_v[0], busy_v[0]} !== 2'b10) begin
            n_bad++;
            $display("FAIL basic_ready_after: ready/busy=%b required 10", {ready_v[0], busy_v[0]});
        end
    endtask

    task automatic test_abort_then_clean();
        bit ok;
        bit saw_done;
        logic [63:0] xs, fs, bs, exp;
        logic [13:0] pat;
        handshake(1, 8'hC3, ok);
        n_cmp++;
        if (!ok) begin n_bad++; $display("FAIL abort_handshake: ready never seen"); end
        for (int i = 0; i < 16; i++) tick();
        n_cmp++;
        if ({x_v[1], busy_v[1]} !== 2'b11) begin
            n_bad++;
            $display("FAIL abort_mid_data: x/busy=%b required 11", {x_v[1], busy_v[1]});
        end
        rst_v[1] = 1'b1;
        tick();
        rst_v[1] = 1'b0;
        n_cmp++;
        if ({x_v[1], busy_v[1], fd_v[1], ready_v[1]} !== 4'b0000) begin
            n_bad++;
            $display("FAIL abort_after_rst: x/busy/done/ready=%b required 0000",
                     {x_v[1], busy_v[1], fd_v[1], ready_v[1]});
        end
        saw_done = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (fd_v[1] === 1'b1) saw_done = 1'b1;
            tick();
        end
        n_cmp++;
        if (saw_done !== 1'b0) begin
            n_bad++;
            $display("FAIL abort_no_done: frame_done seen=%b required 0", saw_done);
        end
        handshake(1, 8'h01, ok);
        n_cmp++;
        if (!ok) begin n_bad++; $display("FAIL clean_handshake: ready never seen"); end
        capture(1, 56, xs, fs, bs);
        pat = 14'b110_00000001_1_00;
        exp = '0;
        for (int i = 13; i >= 0; i--)
            for (int k = 0; k < 4; k++) exp = {exp[62:0], pat[i]};
        n_cmp++;
        if (xs[55:0] !== exp[55:0]) begin
            n_bad++;
            $display("FAIL cpb4_xout: got %h required %h", xs[55:0], exp[55:0]);
        end
        n_cmp++;
        if (fs[55:0] !== 56'h1) begin
            n_bad++;
            $display("FAIL cpb4_frame_done: got %h required %h", fs[55:0], 56'h1);
        end
        n_cmp++;
        if (bs[55:0] !== {56{1'b1}}) begin
            n_bad++;
            $display("FAIL cpb4_busy: got %h required all ones", bs[55:0]);
        end
        n_cmp++;
        if ({ready_v[1], busy_v[1]} !== 2'b10) begin
            n_bad++;
            $display("FAIL cpb4_ready_after: ready/busy=%b required 10", {ready_v[1], busy_v[1]});
        end
    endtask

    task automatic test_back_to_back();
        bit ok;
        logic [63:0] xs, fs, rs;
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (ready_v[0] === 1'b1) begin ok = 1'b1; break; end
            tick();
        end
        n_cmp++;
        if (!ok) begin n_bad++; $display("FAIL b2b_ready: ready never seen"); end
        valid_v[0] = 1'b1;
        data_v[0]  = 8'hFF;
        tick();
        data_v[0]  = 8'h00;
        xs = '0; fs = '0; rs = '0;
        for (int i = 0; i < 29; i++) begin
            xs = {xs[62:0], x_v[0]};
            fs = {fs[62:0], fd_v[0]};
            rs = {rs[62:0], ready_v[0]};
            if (i == 15) valid_v[0] = 1'b0;
            tick();
        end
        n_cmp++;
        if (xs[28:0] !== 29'b110_11111111_0_00_0_110_00000000_0_00) begin
            n_bad++;
            $display("FAIL b2b_xout: got %b required %b", xs[28:0],
                     29'b110_11111111_0_00_0_110_00000000_0_00);
        end
        n_cmp++;
        if (fs[28:0] !== {13'b0, 1'b1, 1'b0, 13'b0, 1'b1}) begin
            n_bad++;
            $display("FAIL b2b_frame_done: got %b", fs[28:0]);
        end
        n_cmp++;
        if (rs[28:0] !== {14'b0, 1'b1, 14'b0}) begin
            n_bad++;
            $display("FAIL b2b_ready_gap: got %b", rs[28:0]);
        end
        n_cmp++;
        if ({ready_v[0], busy_v[0]} !== 2'b10) begin
            n_bad++;
            $display("FAIL b2b_idle_after: ready/busy=%b required 10", {ready_v[0], busy_v[0]});
        end
    endtask

    task automatic test_no_parity();
        bit ok;
        logic [63:0] xs, fs, bs, exp;
        logic [11:0] pat;
        handshake(2, 8'h80, ok);
        n_cmp++;
        if (!ok) begin n_bad++; $display("FAIL nopar_handshake: ready never seen"); end
        capture(2, 24, xs, fs, bs);
        pat = 12'b110_10000000_0;
        exp = '0;
        for (int i = 11; i >= 0; i--)
            for (int k = 0; k < 2; k++) exp = {exp[62:0], pat[i]};
        n_cmp++;
        if (xs[23:0] !== exp[23:0]) begin
            n_bad++;
            $display("FAIL nopar_xout: got %b required %b", xs[23:0], exp[23:0]);
        end
        n_cmp++;
        if (fs[23:0] !== 24'h1) begin
            n_bad++;
            $display("FAIL nopar_frame_done: got %b required %b", fs[23:0], 24'h1);
        end
        n_cmp++;
        if ({ready_v[2], busy_v[2]} !== 2'b10) begin
            n_bad++;
            $display("FAIL nopar_ready_after: ready/busy=%b required 10", {ready_v[2], busy_v[2]});
        end
    endtask

    task automatic test_loopback();
        bit ok;
        logic [2:0] sh;
        int hits;
        int first_at;
        handshake(0, 8'h00, ok);
        n_cmp++;
        if (!ok) begin n_bad++; $display("FAIL loop_handshake: ready never seen"); end
        sh = 3'b000;
        hits = 0;
        first_at = -1;
        for (int i = 0; i < 15; i++) begin
            sh = {sh[1:0], x_v[0]};
            if (sh == 3'b110) begin
                hits++;
                if (first_at < 0) first_at = i;
            end
            tick();
        end
        n_cmp++;
        if (hits != 1) begin
            n_bad++;
            $display("FAIL loop_detect_count: got %0d required 1", hits);
        end
        n_cmp++;
        if (first_at != 2) begin
            n_bad++;
            $display("FAIL loop_detect_pos: got %0d required 2", first_at);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic_a5();
        test_abort_then_clean();
        test_back_to_back();
        test_no_parity();
        test_loopback();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
